// File: rtl/sliding_energy_detector.sv
// Sliding-window |x|^2 energy detector with per-sample hysteretic occupied/clear decision.
// Optional peak-energy capture enabled by defining ENERGY_PEAK_HOLD_EN.
module sliding_energy_detector #(
  parameter int wl      = 16,
  parameter int nSample = 1000,
  parameter int th      = 2*wl+1+$clog2(nSample)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic [wl-1:0] rxRe,
  input  logic [wl-1:0] rxIm,
  input  logic [th-1:0] threshHi,
  input  logic [th-1:0] threshLo,
  output logic [th-1:0] energy,
  output logic          energy_valid,
  output logic          primed,
  output logic          detected,
  output logic          det_rise
`ifdef ENERGY_PEAK_HOLD_EN
  , output logic [th-1:0] peak_energy
`endif
);

  localparam int PW = 2*wl;
  localparam int CW = $clog2(nSample+1);
  localparam int AW = $clog2(nSample);
  localparam logic [CW-1:0] FULL = CW'(nSample);
  localparam logic [AW-1:0] LAST = AW'(nSample-1);

  typedef enum logic [0:0] {CLEAR = 1'b0, DETECT = 1'b1} state_t;

  logic          en0_q, en0_d;
  logic [wl-1:0] re0_q, re0_d, im0_q, im0_d;
  logic          v1_q, v1_d;
  logic [PW-1:0] p1_q, p1_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [th-1:0] acc_q, acc_d;
  state_t        state_q, state_d;
  logic          ev_q, ev_d;
  logic          primed_q, primed_d;
  logic          det_q, det_d;
  logic          rise_q, rise_d;
  logic          wr_s;
  logic [PW-1:0] p_old_s;
  logic [PW-1:0] pow_s;
  logic signed [PW-1:0] re_x_s, im_x_s;
  logic [PW-1:0] pbuf_q [nSample];
`ifdef ENERGY_PEAK_HOLD_EN
  logic [th-1:0] peak_q, peak_d;
`endif

  // Squares are non-negative and their sum fits 2*wl bits when read as unsigned.
  assign re_x_s = {{wl{re0_q[wl-1]}}, re0_q};
  assign im_x_s = {{wl{im0_q[wl-1]}}, im0_q};
  assign pow_s  = (re_x_s * re_x_s) + (im_x_s * im_x_s);

  always_comb begin
    en0_d    = en & ~flush;
    re0_d    = rxRe;
    im0_d    = rxIm;
    v1_d     = en0_q & ~flush;
    p1_d     = en0_q ? pow_s : p1_q;
    count_d  = count_q;
    wptr_d   = wptr_q;
    acc_d    = acc_q;
    state_d  = state_q;
    ev_d     = 1'b0;
    rise_d   = 1'b0;
    primed_d = primed_q;
    wr_s     = 1'b0;
    p_old_s  = '0;
`ifdef ENERGY_PEAK_HOLD_EN
    peak_d   = peak_q;
`endif
    if (flush) begin
      count_d  = '0;
      wptr_d   = '0;
      acc_d    = '0;
      state_d  = CLEAR;
      primed_d = 1'b0;
`ifdef ENERGY_PEAK_HOLD_EN
      peak_d   = '0;
`endif
    end else if (v1_q) begin
      // The oldest power is only valid once the ring has been filled once.
      p_old_s = (count_q == FULL) ? pbuf_q[wptr_q] : '0;
      acc_d   = acc_q + th'(p1_q) - th'(p_old_s);
      wr_s    = 1'b1;
      wptr_d  = (wptr_q == LAST) ? '0 : wptr_q + AW'(1);
      count_d = (count_q == FULL) ? count_q : count_q + CW'(1);
      if (count_d == FULL) begin
        primed_d = 1'b1;
        ev_d     = 1'b1;
        case (state_q)
          CLEAR: begin
            if (acc_d >= threshHi) begin
              state_d = DETECT;
              rise_d  = 1'b1;
            end else begin
              state_d = CLEAR;
            end
          end
          DETECT: begin
            if (acc_d < threshLo) begin
              state_d = CLEAR;
            end else begin
              state_d = DETECT;
            end
          end
          default: state_d = CLEAR;
        endcase
`ifdef ENERGY_PEAK_HOLD_EN
        if (rise_d) begin
          peak_d = acc_d;
        end else if ((state_q == DETECT) && (acc_d > peak_q)) begin
          peak_d = acc_d;
        end else begin
          peak_d = peak_q;
        end
`endif
      end else begin
        primed_d = 1'b0;
      end
    end else begin
      ev_d = 1'b0;
    end
    det_d = (state_d == DETECT) && primed_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en0_q    <= 1'b0;
      re0_q    <= '0;
      im0_q    <= '0;
      v1_q     <= 1'b0;
      p1_q     <= '0;
      count_q  <= '0;
      wptr_q   <= '0;
      acc_q    <= '0;
      state_q  <= CLEAR;
      ev_q     <= 1'b0;
      primed_q <= 1'b0;
      det_q    <= 1'b0;
      rise_q   <= 1'b0;
`ifdef ENERGY_PEAK_HOLD_EN
      peak_q   <= '0;
`endif
    end else begin
      en0_q    <= en0_d;
      re0_q    <= re0_d;
      im0_q    <= im0_d;
      v1_q     <= v1_d;
      p1_q     <= p1_d;
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      acc_q    <= acc_d;
      state_q  <= state_d;
      ev_q     <= ev_d;
      primed_q <= primed_d;
      det_q    <= det_d;
      rise_q   <= rise_d;
`ifdef ENERGY_PEAK_HOLD_EN
      peak_q   <= peak_d;
`endif
    end
  end

  // Power ring has no reset; entries are read only after being written.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      pbuf_q[wptr_q] <= p1_q;
    end
  end

  assign energy       = acc_q;
  assign energy_valid = ev_q;
  assign primed       = primed_q;
  assign detected     = det_q;
  assign det_rise     = rise_q;
`ifdef ENERGY_PEAK_HOLD_EN
  assign peak_energy  = peak_q;
`endif

endmodule

// File: tb/tb_sliding_energy_detector.sv
// Self-checking bench for sliding_energy_detector (wl=16, nSample=4): vector table,
// directed corner sequences and random traffic against a window-queue reference model.
module tb_sliding_energy_detector;

  localparam int WL = 16;
  localparam int NS = 4;
  localparam int TH = 2*WL+1+$clog2(NS);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic [WL-1:0] rxRe = '0;
  logic [WL-1:0] rxIm = '0;
  logic [TH-1:0] threshHi = '0;
  logic [TH-1:0] threshLo = '0;
  logic [TH-1:0] energy;
  logic          energy_valid, primed, detected, det_rise;
`ifdef ENERGY_PEAK_HOLD_EN
  logic [TH-1:0] peak_energy;
`endif

  sliding_energy_detector #(.wl(WL), .nSample(NS)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .rxRe(rxRe), .rxIm(rxIm),
    .threshHi(threshHi), .threshLo(threshLo), .energy(energy),
    .energy_valid(energy_valid), .primed(primed), .detected(detected), .det_rise(det_rise)
`ifdef ENERGY_PEAK_HOLD_EN
    , .peak_energy(peak_energy)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // reference model: the window as a queue of powers, plus a two-edge delay line
  longint win[$];
  bit     dv[2];
  longint dp[2];
  bit     m_det, m_ev, m_rise;
  longint m_peak;
  longint m_hi, m_lo;

  function automatic longint win_sum();
    longint s = 0;
    foreach (win[i]) s += win[i];
    return s;
  endfunction

  task automatic model_clear();
    win.delete();
    dv[0] = 1'b0; dv[1] = 1'b0;
    m_det = 1'b0; m_ev = 1'b0; m_rise = 1'b0; m_peak = 0;
  endtask

  task automatic model_edge(bit e, bit f, int re, int im);
    bit     ov;
    longint op, s;
    if (f) begin
      model_clear();
      return;
    end
    ov = dv[1]; op = dp[1];
    dv[1] = dv[0]; dp[1] = dp[0];
    dv[0] = e; dp[0] = longint'(re) * re + longint'(im) * im;
    m_ev = 1'b0; m_rise = 1'b0;
    if (ov) begin
      win.push_back(op);
      if (win.size() > NS) void'(win.pop_front());
      if (win.size() == NS) begin
        s = win_sum();
        m_ev = 1'b1;
        if (!m_det && s >= m_hi) begin
          m_det = 1'b1; m_rise = 1'b1; m_peak = s;
        end else if (m_det) begin
          if (s > m_peak) m_peak = s;
          if (s < m_lo) m_det = 1'b0;
        end
      end
    end
  endtask

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_th(longint hi, longint lo);
    m_hi = hi; m_lo = lo;
    threshHi = hi[TH-1:0];
    threshLo = lo[TH-1:0];
  endtask

  task automatic step(bit e, bit f, int re, int im);
    en = e; flush = f; rxRe = re[WL-1:0]; rxIm = im[WL-1:0];
    @(posedge clk); #1;
    model_edge(e, f, re, im);
    check("energy", longint'(energy), win_sum());
    check("energy_valid", longint'(energy_valid), longint'(m_ev));
    check("primed", longint'(primed), longint'(win.size() == NS));
    check("detected", longint'(detected), longint'(m_det));
    check("det_rise", longint'(det_rise), longint'(m_rise));
`ifdef ENERGY_PEAK_HOLD_EN
    check("peak_energy", longint'(peak_energy), m_peak);
`endif
  endtask

  typedef struct {
    bit     en;
    int     re;
    int     im;
    longint e;
    bit     v, p, d, r;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 100, 0,     0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 100, 0,     0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 100, 0, 10000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 100, 0, 20000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 0,  50, 30000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 0,  50, 40000, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 0,  50, 32500, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 0,  50, 25000, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 0,   0, 17500, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 0,   0, 10000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 0,   0, 10000, 1'b0, 1'b1, 1'b0, 1'b0};

    model_clear();
    set_th(35000, 20000);
    #1;
    check("reset_energy", longint'(energy), 0);
    check("reset_primed", longint'(primed), 0);
    check("reset_detected", longint'(detected), 0);
    check("reset_valid", longint'(energy_valid), 0);
    #13 rst = 1'b0;
    @(posedge clk); #1;

    // warm-up and sliding update
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].en, 1'b0, tbl[i].re, tbl[i].im);
      check($sformatf("tbl%0d_energy", i), longint'(energy), tbl[i].e);
      check($sformatf("tbl%0d_valid", i), longint'(energy_valid), longint'(tbl[i].v));
      check($sformatf("tbl%0d_primed", i), longint'(primed), longint'(tbl[i].p));
      check($sformatf("tbl%0d_det", i), longint'(detected), longint'(tbl[i].d));
      check($sformatf("tbl%0d_rise", i), longint'(det_rise), longint'(tbl[i].r));
    end

    // bubbles between warm-up samples
    step(1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 100, 0);
      step(1'b0, 1'b0, 0, 0);
    end
    step(1'b0, 1'b0, 0, 0);
    check("bubble_energy", longint'(energy), 40000);
    check("bubble_det", longint'(detected), 1);

    // extremes: no wrap at 2^33, then decay to zero
    step(1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, -32768, -32768);
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);
    check("extreme_energy", longint'(energy), 64'h2_0000_0000);
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    check("zero_energy", longint'(energy), 0);
    check("zero_det", longint'(detected), 0);

    // flush mid-window with a discarded sample
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 100, 0);
    step(1'b1, 1'b1, 30000, 30000);
    check("flush_energy", longint'(energy), 0);
    check("flush_primed", longint'(primed), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 100, 0);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    check("flush_refill_primed", longint'(primed), 0);
    step(1'b1, 1'b0, 100, 0);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    check("flush_refill_energy", longint'(energy), 40000);

    // async reset while detected
    check("pre_rst_det", longint'(detected), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_energy", longint'(energy), 0);
    check("arst_det", longint'(detected), 0);
    check("arst_primed", longint'(primed), 0);
    model_clear();
    #1 rst = 1'b0;

    // random traffic, including inverted thresholds
    for (int n = 0; n < 3000; n++) begin
      int re, im;
      if ((n % 97) == 0) set_th(longint'($urandom()) * 2, longint'($urandom()) * 2);
      if ($urandom_range(0, 1) == 0) begin
        re = $urandom_range(0, 65535) - 32768;
        im = $urandom_range(0, 65535) - 32768;
      end else begin
        re = $urandom_range(0, 2000) - 1000;
        im = $urandom_range(0, 2000) - 1000;
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, re, im);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
